gate_primitives_unit: RTL and testbench
=======================================

GATE_PRIMITIVES_UNIT -- requirements
Module: gate_primitives_unit

Interface
- REQ-001: The block SHALL have one clock and an asynchronous, active-low reset; ports clk and rst_n.
- REQ-002: Parameter XOR_W, default 4, SHALL set the XOR operand width.
- REQ-003: Parameter CMP_W, default 2, SHALL set the comparator operand width.
- REQ-004: clk, input, 1: rising-edge clock.
- REQ-005: rst_n, input, 1: asynchronous active-low reset.
- REQ-006: in_valid, input, 1: the input operands are valid this cycle.
- REQ-007: i0, input, CMP_W: comparator operand 0.
- REQ-008: i1, input, CMP_W: comparator operand 1.
- REQ-009: a, input, XOR_W: XOR operand A.
- REQ-010: b, input, XOR_W: XOR operand B.
- REQ-011: x, y, z, input, 1 each: minority-vote inputs.
- REQ-012: out_valid, output, 1: the registered results are valid.
- REQ-013: eq, output, 1: registered equality result.
- REQ-014: res, output, XOR_W: registered bitwise XOR result.
- REQ-015: res_min, output, 1: registered minority result.

Function
- REQ-016: The comparator SHALL compute eq_c = 1 exactly when i0 == i1 on all CMP_W bits, else 0.
- REQ-017: The XOR SHALL compute res_c = a XOR b bitwise on all XOR_W bits, with no carry and no reduction.
- REQ-018: The minority function SHALL compute min_c = 1 when at most one of x, y, z is 1, i.e. NOT((x AND y) OR (y AND z) OR (x AND z)).
- REQ-019: Minority truth table: 000->1, 001->1, 010->1, 100->1, 011->0, 101->0, 110->0, 111->0.
- REQ-020: When in_valid=1 at a rising clk edge, eq, res and res_min SHALL load eq_c, res_c and min_c, and out_valid SHALL be 1 after that edge (latency: 1 cycle).
- REQ-021: When in_valid=0 at a rising clk edge, eq, res and res_min SHALL hold their previous values, and out_valid SHALL be 0 after that edge.
- REQ-022: Back-to-back in_valid=1 SHALL produce one result per cycle with no bubbles.
- REQ-023: The three functions SHALL be independent; no output depends on another function's inputs.
- REQ-024: Outputs SHALL be driven only from flops, with no combinational path from input to output.
- REQ-025: X-free operation is required; unknown inputs while in_valid=0 SHALL NOT disturb the held outputs.

Reset
- REQ-026: While rst_n=0, eq=0, res=0 (all bits), res_min=0 and out_valid=0, applied immediately and independent of clk.
- REQ-027: Reset deassertion SHALL be synchronised to the clk edge (reset-release synchroniser on rst_n); the first capture SHALL occur on the first edge after release where in_valid=1.
- REQ-028: Reset asserted mid-stream SHALL discard any in-flight result, with outputs returning to the REQ-026 values at once.

Structure
- REQ-029: Package gate_primitives_pkg SHALL hold the XOR_W and CMP_W default constants.
- REQ-030: Three combinational sub-modules SHALL be instantiated inside gate_primitives_unit: two_bit_comparator (i0, i1 -> eq), four_input_xor (a, b -> res) and minority (x, y, z -> out, positional order x, y, z, out).
- REQ-031: The top level SHALL contain only the output/valid register stage and the reset synchroniser.

Verification
- REQ-032: i0=00, i1=00, in_valid=1 -> eq=1 one cycle later; then i0=01, i1=00 -> eq=0.
- REQ-033: a=0000, b=0001 -> res=0001; a=1010, b=1010 -> res=0000; a=1010, b=0101 -> res=1111.
- REQ-034: Sweep all 8 combinations of xyz -> res_min matches the REQ-019 table, each result one cycle after capture.
- REQ-035: in_valid pulses 1 then 0 for 3 cycles -> out_valid=1 for one cycle, and outputs hold their values while inputs toggle.
- REQ-036: Assert rst_n=0 between clk edges with out_valid=1 -> all outputs are 0 before the next edge; after release with in_valid=1, valid results appear one cycle later.

Source files
------------

// File: rtl/gate_primitives_pkg.sv
`default_nettype none
// ============================================================================
// Module : gate_primitives_pkg
// Brief  : Shared default operand widths for the gate primitives unit.
// Rev    : 1.0  initial release
// ============================================================================
package gate_primitives_pkg;

    localparam int XOR_W_DEFAULT = 4;
    localparam int CMP_W_DEFAULT = 2;

endpackage : gate_primitives_pkg
`default_nettype wire

// File: rtl/four_input_xor.sv
`default_nettype none
// ============================================================================
// Module : four_input_xor
// Brief  : Combinational bitwise XOR of two operands (no carry, no reduction).
// Rev    : 1.0  initial release
// ============================================================================
module four_input_xor
    import gate_primitives_pkg::*;
#(
    parameter int W = XOR_W_DEFAULT
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] res
);

    assign res = a ^ b;

endmodule : four_input_xor
`default_nettype wire

// File: rtl/minority.sv
`default_nettype none
// ============================================================================
// Module : minority
// Brief  : Combinational 3-input minority vote (1 when at most one input is 1).
// Rev    : 1.0  initial release
// ============================================================================
module minority (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic out
);

    assign out = ~((x & y) | (y & z) | (x & z));

endmodule : minority
`default_nettype wire

// File: rtl/two_bit_comparator.sv
`default_nettype none
// ============================================================================
// Module : two_bit_comparator
// Brief  : Combinational full-width equality compare of two operands.
// Rev    : 1.0  initial release
// ============================================================================
module two_bit_comparator
    import gate_primitives_pkg::*;
#(
    parameter int W = CMP_W_DEFAULT
) (
    input  logic [W-1:0] i0,
    input  logic [W-1:0] i1,
    output logic         eq
);

    assign eq = (i0 == i1);

endmodule : two_bit_comparator
`default_nettype wire

// File: rtl/gate_primitives_unit.sv
`default_nettype none
// ============================================================================
// Module : gate_primitives_unit
// Brief  : Comparator, XOR and minority functions behind one registered stage.
// Rev    : 1.0  initial release
// ============================================================================
module gate_primitives_unit
    import gate_primitives_pkg::*;
#(
    parameter int XOR_W = XOR_W_DEFAULT,
    parameter int CMP_W = CMP_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [CMP_W-1:0] i0,
    input  logic [CMP_W-1:0] i1,
    input  logic [XOR_W-1:0] a,
    input  logic [XOR_W-1:0] b,
    input  logic             x,
    input  logic             y,
    input  logic             z,
    output logic             out_valid,
    output logic             eq,
    output logic [XOR_W-1:0] res,
    output logic             res_min
);

    logic             eq_c;
    logic [XOR_W-1:0] res_c;
    logic             min_c;

    two_bit_comparator #(.W(CMP_W)) u_cmp (
        .i0 (i0),
        .i1 (i1),
        .eq (eq_c)
    );

    four_input_xor #(.W(XOR_W)) u_xor (
        .a   (a),
        .b   (b),
        .res (res_c)
    );

    minority u_min (x, y, z, min_c);

    // Assertion is immediate; release reaches the capture stage only after two
    // clk edges so the register stage never sees a release mid-cycle.
    logic [1:0] rst_sync_q;
    logic       run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign run = rst_sync_q[1];

    logic             capture;
    logic             out_valid_d, out_valid_q;
    logic             eq_d,        eq_q;
    logic [XOR_W-1:0] res_d,       res_q;
    logic             res_min_d,   res_min_q;

    assign capture = in_valid & run;

    // Held values are selected explicitly so unknown operands are never sampled
    // while no capture is requested.
    always_comb begin
        out_valid_d = capture;
        eq_d        = eq_q;
        res_d       = res_q;
        res_min_d   = res_min_q;
        if (capture) begin
            eq_d      = eq_c;
            res_d     = res_c;
            res_min_d = min_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            eq_q        <= 1'b0;
            res_q       <= '0;
            res_min_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            eq_q        <= eq_d;
            res_q       <= res_d;
            res_min_q   <= res_min_d;
        end
    end

    assign out_valid = out_valid_q;
    assign eq        = eq_q;
    assign res       = res_q;
    assign res_min   = res_min_q;

endmodule : gate_primitives_unit
`default_nettype wire

// File: tb/tb_gate_primitives_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_gate_primitives_unit
// Brief  : Directed self-checking bench for gate_primitives_unit.
// Rev    : 1.0  initial release
// ============================================================================
module tb_gate_primitives_unit;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [1:0] i0, i1;
    logic [3:0] a, b;
    logic       x, y, z;
    logic       out_valid, eq, res_min;
    logic [3:0] res;

    int n_checks = 0;
    int n_pass   = 0;

    gate_primitives_unit #(.XOR_W(4), .CMP_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .i0        (i0),
        .i1        (i1),
        .a         (a),
        .b         (b),
        .x         (x),
        .y         (y),
        .z         (z),
        .out_valid (out_valid),
        .eq        (eq),
        .res       (res),
        .res_min   (res_min)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Drive a vector on the falling edge, then sample 1 time unit after the rising edge.
    task automatic apply(input logic iv, input logic [1:0] v0, input logic [1:0] v1,
                         input logic [3:0] va, input logic [3:0] vb,
                         input logic vx, input logic vy, input logic vz);
        @(negedge clk);
        in_valid = iv; i0 = v0; i1 = v1; a = va; b = vb; x = vx; y = vy; z = vz;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] min_tab;
        logic [2:0] v;
        min_tab = 8'b0001_0111;

        rst_n = 1'b0; in_valid = 1'b0;
        i0 = '0; i1 = '0; a = '0; b = '0; x = 1'b0; y = 1'b0; z = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_eq",        32'(eq),        32'd0);
        chk("rst_res",       32'(res),       32'd0);
        chk("rst_res_min",   32'(res_min),   32'd0);

        // Release, then let the reset synchroniser settle with no requests.
        @(negedge clk); rst_n = 1'b1;
        repeat (3) apply(1'b0, 2'b00, 2'b00, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        chk("idle_out_valid", 32'(out_valid), 32'd0);

        apply(1'b1, 2'b00, 2'b00, 4'h0, 4'h1, 1'b0, 1'b0, 1'b0);
        chk("cmp00_eq",    32'(eq),        32'd1);
        chk("cmp00_valid", 32'(out_valid), 32'd1);
        chk("xor_0_1",     32'(res),       32'h1);
        apply(1'b1, 2'b01, 2'b00, 4'hA, 4'hA, 1'b0, 1'b0, 1'b0);
        chk("cmp01_eq",    32'(eq),        32'd0);
        chk("xor_A_A",     32'(res),       32'h0);
        apply(1'b1, 2'b11, 2'b11, 4'hA, 4'h5, 1'b0, 1'b0, 1'b0);
        chk("cmp11_eq",    32'(eq),        32'd1);
        chk("xor_A_5",     32'(res),       32'hF);
        apply(1'b1, 2'b10, 2'b11, 4'hC, 4'h6, 1'b0, 1'b0, 1'b0);
        chk("cmp10_11_eq", 32'(eq),        32'd0);
        chk("xor_C_6",     32'(res),       32'hA);

        // Back-to-back minority sweep; comparator and XOR operands held fixed.
        for (int k = 0; k < 8; k++) begin
            v = 3'(k);
            apply(1'b1, 2'b10, 2'b10, 4'h3, 4'h5, v[2], v[1], v[0]);
            chk($sformatf("min_%03b", v), 32'(res_min), 32'(min_tab[k]));
            chk($sformatf("min_%03b_valid", v), 32'(out_valid), 32'd1);
            chk($sformatf("min_%03b_res", v), 32'(res), 32'h6);
            chk($sformatf("min_%03b_eq", v), 32'(eq), 32'd1);
        end

        // Single valid pulse, then three idle cycles with toggling inputs.
        apply(1'b1, 2'b11, 2'b01, 4'hC, 4'h6, 1'b1, 1'b1, 1'b0);
        chk("pulse_valid", 32'(out_valid), 32'd1);
        chk("pulse_eq",    32'(eq),        32'd0);
        chk("pulse_res",   32'(res),       32'hA);
        chk("pulse_min",   32'(res_min),   32'd0);
        apply(1'b0, 2'b01, 2'b01, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0);
        chk("hold1_valid", 32'(out_valid), 32'd0);
        chk("hold1_eq",    32'(eq),        32'd0);
        chk("hold1_res",   32'(res),       32'hA);
        chk("hold1_min",   32'(res_min),   32'd0);
        apply(1'b0, 2'b10, 2'b10, 4'h1, 4'h2, 1'b0, 0, 1'b1);
        chk("hold2_valid", 32'(out_valid), 32'd0);
        chk("hold2_res",   32'(res),       32'hA);
        chk("hold2_min",   32'(res_min),   32'd0);
        apply(1'b0, 2'bxx, 2'bxx, 4'hx, 4'hx, 1'bx, 1'bx, 1'bx);
        chk("hold3_valid", 32'(out_valid), 32'd0);
        chk("hold3_eq",    32'(eq),        32'd0);
        chk("hold3_res",   32'(res),       32'hA);
        chk("hold3_min",   32'(res_min),   32'd0);

        // Mid-stream reset between edges with a valid result on the outputs.
        apply(1'b1, 2'b01, 2'b01, 4'h9, 4'h3, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        chk("pre_rst_res",   32'(res),       32'hA);
        chk("pre_rst_min",   32'(res_min),   32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_eq",    32'(eq),        32'd0);
        chk("mid_rst_res",   32'(res),       32'd0);
        chk("mid_rst_min",   32'(res_min),   32'd0);
        @(posedge clk); #1;
        chk("in_rst_valid",  32'(out_valid), 32'd0);
        chk("in_rst_res",    32'(res),       32'd0);

        @(negedge clk); rst_n = 1'b1; in_valid = 1'b0;
        repeat (2) apply(1'b0, 2'b00, 2'b00, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        chk("rel_idle_valid", 32'(out_valid), 32'd0);
        apply(1'b1, 2'b10, 2'b10, 4'h7, 4'h1, 1'b1, 1'b0, 1'b0);
        chk("rel_valid", 32'(out_valid), 32'd1);
        chk("rel_eq",    32'(eq),        32'd1);
        chk("rel_res",   32'(res),       32'h6);
        chk("rel_min",   32'(res_min),   32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

endmodule : tb_gate_primitives_unit
`default_nettype wire
